// File: rtl/frame_store_write_port.sv
// Drawing-engine pixel write responder: buffers byte writes in a small FIFO,
// merges same-word writes into the tail entry, and drains words to the frame store.
module frame_store_write_port #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 18,
    parameter int COALESCE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     de_req,
    output logic                     de_ack,
    input  logic [ADDR_W-1:0]        de_addr,
    input  logic [3:0]               de_nbyte,
    input  logic [31:0]              de_data,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [3:0]               mem_nbyte,
    output logic [31:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam bit COAL_EN = (COALESCE != 32'sd0);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_C   = CW'(32'd2);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [ADDR_W-1:0] addr_r  [DEPTH];
    logic [3:0]        nbyte_r [DEPTH];
    logic [31:0]       data_r  [DEPTH];

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic [PW-1:0] tail_s;
    logic          hit_s;
    logic          full_s;
    logic          push_s;
    logic          merge_s;
    logic          pop_s;

    // Lane i takes new data where the active-low select is 0, otherwise keeps old data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  nbyte);
        logic [31:0] merged;
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (nbyte[i]) begin
                merged[8*i +: 8] = old_data[8*i +: 8];
            end else begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Merging needs two entries so the head already on the memory bus is never altered.
    assign tail_s  = wr_ptr_r - PW'(1'b1);
    assign hit_s   = COAL_EN && (count_r >= TWO_C) && (de_addr == addr_r[tail_s]);
    assign full_s  = (count_r == DEPTH_C);
    assign de_ack  = rst_n && de_req && (hit_s || !full_s);
    assign push_s  = de_ack && !hit_s;
    assign merge_s = de_ack && hit_s;
    assign pop_s   = mem_ack && (count_r != ZERO_C);

    assign mem_req   = rst_n && (count_r != ZERO_C);
    assign mem_addr  = addr_r[rd_ptr_r];
    assign mem_nbyte = nbyte_r[rd_ptr_r];
    assign mem_wdata = data_r[rd_ptr_r];
    assign level     = count_r;
    assign idle      = (count_r == ZERO_C);

    // Entry storage: new entries land at the write pointer, merges update the tail in place.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_r[wr_ptr_r]  <= de_addr;
            nbyte_r[wr_ptr_r] <= de_nbyte;
            data_r[wr_ptr_r]  <= de_data;
        end else if (merge_s) begin
            nbyte_r[tail_s] <= nbyte_r[tail_s] & de_nbyte;
            data_r[tail_s]  <= merge_lanes(data_r[tail_s], de_data, de_nbyte);
        end
    end

    // Pointer and occupancy bookkeeping with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_store_write_port.sv
// Directed bench for frame_store_write_port: one coalescing and one non-coalescing instance.
module tb_frame_store_write_port;

    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          de_req, de_ack, mem_req, mem_ack, idle;
    logic [AW-1:0] de_addr, mem_addr;
    logic [3:0]    de_nbyte, mem_nbyte;
    logic [31:0]   de_data, mem_wdata;
    logic [2:0]    level;

    logic          nc_de_req, nc_de_ack, nc_mem_req, nc_mem_ack, nc_idle;
    logic [AW-1:0] nc_de_addr, nc_mem_addr;
    logic [3:0]    nc_de_nbyte, nc_mem_nbyte;
    logic [31:0]   nc_de_data, nc_mem_wdata;
    logic [2:0]    nc_level;

    int n_cmp = 0;
    int n_err = 0;

    frame_store_write_port #(.DEPTH(4), .ADDR_W(AW), .COALESCE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte), .de_data(de_data),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_nbyte(mem_nbyte),
        .mem_wdata(mem_wdata), .level(level), .idle(idle)
    );

    frame_store_write_port #(.DEPTH(4), .ADDR_W(AW), .COALESCE(0)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .de_req(nc_de_req), .de_ack(nc_de_ack), .de_addr(nc_de_addr), .de_nbyte(nc_de_nbyte),
        .de_data(nc_de_data), .mem_req(nc_mem_req), .mem_ack(nc_mem_ack), .mem_addr(nc_mem_addr),
        .mem_nbyte(nc_mem_nbyte), .mem_wdata(nc_mem_wdata), .level(nc_level), .idle(nc_idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; de_req = 1'b1; de_addr = 18'h0; de_nbyte = 4'b1110; de_data = 32'h0; mem_ack = 1'b0;
        nc_de_req = 1'b0; nc_de_addr = 18'h0; nc_de_nbyte = 4'b1111; nc_de_data = 32'h0; nc_mem_ack = 1'b0;
        #1;
        n_cmp++; if (de_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", de_ack); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mreq: got %b want 0", mem_req); end
        tick(); tick();
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle); end
        de_req = 1'b0; rst_n = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mreq_after: got %b want 0", mem_req); end
    endtask

    task automatic test_first_write();
        de_req = 1'b1; de_addr = 18'h0; de_nbyte = 4'b1110; de_data = 32'h0000_00AA;
        #1;
        n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL fw_ack: got %b want 1", de_ack); end
        tick();
        de_req = 1'b0;
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fw_mreq: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 18'h0) begin n_err++; $display("FAIL fw_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_nbyte !== 4'b1110) begin n_err++; $display("FAIL fw_nbyte: got %b want 1110", mem_nbyte); end
        n_cmp++; if (mem_wdata[7:0] !== 8'hAA) begin n_err++; $display("FAIL fw_data: got %h want aa", mem_wdata[7:0]); end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL fw_level: got %0d want 1", level); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL fw_idle: got %b want 1", idle); end
    endtask

    task automatic test_coalesce();
        logic [AW-1:0] va [4] = '{18'h5, 18'h6, 18'h6, 18'h6};
        logic [3:0]    vn [4] = '{4'b1110, 4'b1111, 4'b1101, 4'b0111};
        logic [31:0]   vd [4] = '{32'h0000_0011, 32'h0, 32'h0000_2200, 32'h3300_0000};
        for (int i = 0; i < 4; i++) begin
            de_req = 1'b1; de_addr = va[i]; de_nbyte = vn[i]; de_data = vd[i];
            #1;
            n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL co_ack%0d: got %b want 1", i, de_ack); end
            tick();
        end
        de_req = 1'b0;
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL co_level: got %0d want 2", level); end
        n_cmp++; if (mem_addr !== 18'h5) begin n_err++; $display("FAIL co_head_addr: got %h want 5", mem_addr); end
        n_cmp++; if (mem_nbyte !== 4'b1110) begin n_err++; $display("FAIL co_head_nbyte: got %b want 1110", mem_nbyte); end
        n_cmp++; if (mem_wdata[7:0] !== 8'h11) begin n_err++; $display("FAIL co_head_data: got %h want 11", mem_wdata[7:0]); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_cmp++; if (mem_addr !== 18'h6) begin n_err++; $display("FAIL co_m_addr: got %h want 6", mem_addr); end
        n_cmp++; if (mem_nbyte !== 4'b0101) begin n_err++; $display("FAIL co_m_nbyte: got %b want 0101", mem_nbyte); end
        n_cmp++; if ((mem_wdata & 32'hFF00_FF00) !== 32'h3300_2200) begin n_err++; $display("FAIL co_m_data: got %h want 33xx22xx", mem_wdata); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL co_idle: got %b want 1", idle); end
    endtask

    task automatic test_hit_pop();
        logic [AW-1:0] va [2] = '{18'h7, 18'h8};
        logic [31:0]   vd [2] = '{32'h0000_00A1, 32'h0000_00B2};
        for (int i = 0; i < 2; i++) begin
            de_req = 1'b1; de_addr = va[i]; de_nbyte = 4'b1110; de_data = vd[i];
            tick();
        end
        de_addr = 18'h8; de_nbyte = 4'b1011; de_data = 32'h00C3_0000; mem_ack = 1'b1;
        #1;
        n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL hp_ack: got %b want 1", de_ack); end
        tick();
        de_req = 1'b0; mem_ack = 1'b0;
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL hp_level: got %0d want 1", level); end
        n_cmp++; if (mem_addr !== 18'h8) begin n_err++; $display("FAIL hp_addr: got %h want 8", mem_addr); end
        n_cmp++; if (mem_nbyte !== 4'b1010) begin n_err++; $display("FAIL hp_nbyte: got %b want 1010", mem_nbyte); end
        n_cmp++; if ((mem_wdata & 32'h00FF_00FF) !== 32'h00C3_00B2) begin n_err++; $display("FAIL hp_data: got %h want xxc3xxb2", mem_wdata); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL hp_idle: got %b want 1", idle); end
    endtask

    task automatic test_full();
        logic [AW-1:0] ea [4] = '{18'h11, 18'h12, 18'h13, 18'h14};
        logic [3:0]    en [4] = '{4'b1110, 4'b1110, 4'b1100, 4'b1110};
        for (int i = 0; i < 4; i++) begin
            de_req = 1'b1; de_addr = 18'h10 + 18'(i); de_nbyte = 4'b1110; de_data = 32'(i);
            tick();
        end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fu_level: got %0d want 4", level); end
        de_addr = 18'h13; de_nbyte = 4'b1101; de_data = 32'h0000_5500;
        #1;
        n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL fu_hit_ack: got %b want 1", de_ack); end
        tick();
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fu_hit_level: got %0d want 4", level); end
        de_addr = 18'h14; de_nbyte = 4'b1110; de_data = 32'h0000_0044; mem_ack = 1'b1;
        #1;
        n_cmp++; if (de_ack !== 1'b0) begin n_err++; $display("FAIL fu_miss_ack: got %b want 0", de_ack); end
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL fu_pop_level: got %0d want 3", level); end
        #1;
        n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL fu_retry_ack: got %b want 1", de_ack); end
        tick();
        de_req = 1'b0;
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fu_retry_level: got %0d want 4", level); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_addr !== ea[i]) begin n_err++; $display("FAIL fu_drain_addr%0d: got %h want %h", i, mem_addr, ea[i]); end
            n_cmp++; if (mem_nbyte !== en[i]) begin n_err++; $display("FAIL fu_drain_nbyte%0d: got %b want %b", i, mem_nbyte, en[i]); end
            mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL fu_idle: got %b want 1", idle); end
    endtask

    task automatic test_ack_empty();
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL ae_level: got %0d want 0", level); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ae_mreq: got %b want 0", mem_req); end
        de_req = 1'b1; de_addr = 18'h2A; de_nbyte = 4'b0000; de_data = 32'h1234_5678;
        tick();
        de_req = 1'b0;
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL ae_push_level: got %0d want 1", level); end
        n_cmp++; if (mem_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL ae_data: got %h want 12345678", mem_wdata); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            de_req = 1'b1; de_addr = 18'h100 + 18'(i); de_nbyte = 4'b0000; de_data = 32'(i);
            #1;
            n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL bb_ack%0d: got %b want 1", i, de_ack); end
            tick();
            n_cmp++; if (mem_addr !== 18'h100 + 18'(i)) begin n_err++; $display("FAIL bb_addr%0d: got %h want %h", i, mem_addr, 18'h100 + 18'(i)); end
            n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL bb_level%0d: got %0d want 1", i, level); end
        end
        de_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL bb_idle: got %b want 1", idle); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            de_req = 1'b1; de_addr = 18'h20 + 18'(i); de_nbyte = 4'b1110; de_data = 32'(i);
            tick();
        end
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL rm_level: got %0d want 3", level); end
        rst_n = 1'b0; de_addr = 18'h30;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rm_mreq: got %b want 0", mem_req); end
        n_cmp++; if (de_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack: got %b want 0", de_ack); end
        tick();
        rst_n = 1'b1; de_req = 1'b0;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rm_level0: got %0d want 0", level); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rm_idle: got %b want 1", idle); end
        de_req = 1'b1; de_addr = 18'h31; de_nbyte = 4'b1100; de_data = 32'h0000_BEEF;
        #1;
        n_cmp++; if (de_ack !== 1'b1) begin n_err++; $display("FAIL rm_post_ack: got %b want 1", de_ack); end
        tick();
        de_req = 1'b0;
        n_cmp++; if (mem_addr !== 18'h31) begin n_err++; $display("FAIL rm_post_addr: got %h want 31", mem_addr); end
        n_cmp++; if (mem_nbyte !== 4'b1100) begin n_err++; $display("FAIL rm_post_nbyte: got %b want 1100", mem_nbyte); end
        n_cmp++; if (mem_wdata[15:0] !== 16'hBEEF) begin n_err++; $display("FAIL rm_post_data: got %h want beef", mem_wdata[15:0]); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rm_idle2: got %b want 1", idle); end
    endtask

    task automatic test_no_coalesce();
        logic [AW-1:0] va [4] = '{18'h5, 18'h6, 18'h6, 18'h6};
        logic [3:0]    vn [4] = '{4'b1110, 4'b1111, 4'b1101, 4'b0111};
        logic [31:0]   vd [4] = '{32'h0000_0011, 32'h0, 32'h0000_2200, 32'h3300_0000};
        for (int i = 0; i < 4; i++) begin
            nc_de_req = 1'b1; nc_de_addr = va[i]; nc_de_nbyte = vn[i]; nc_de_data = vd[i];
            #1;
            n_cmp++; if (nc_de_ack !== 1'b1) begin n_err++; $display("FAIL nc_ack%0d: got %b want 1", i, nc_de_ack); end
            tick();
        end
        n_cmp++; if (nc_level !== 3'd4) begin n_err++; $display("FAIL nc_level: got %0d want 4", nc_level); end
        nc_de_addr = 18'h6; nc_de_nbyte = 4'b1110; nc_de_data = 32'h0000_0077;
        #1;
        n_cmp++; if (nc_de_ack !== 1'b0) begin n_err++; $display("FAIL nc_full_ack: got %b want 0", nc_de_ack); end
        tick();
        nc_de_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (nc_mem_addr !== va[i]) begin n_err++; $display("FAIL nc_drain_addr%0d: got %h want %h", i, nc_mem_addr, va[i]); end
            n_cmp++; if (nc_mem_nbyte !== vn[i]) begin n_err++; $display("FAIL nc_drain_nbyte%0d: got %b want %b", i, nc_mem_nbyte, vn[i]); end
            nc_mem_ack = 1'b1; tick(); nc_mem_ack = 1'b0;
        end
        n_cmp++; if (nc_idle !== 1'b1) begin n_err++; $display("FAIL nc_idle: got %b want 1", nc_idle); end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_coalesce();
        test_hit_pop();
        test_full();
        test_ack_empty();
        test_back_to_back();
        test_reset_mid();
        test_no_coalesce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
